// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch feeder slice.
//   RESET_PC        default PC loaded on reset
//   PC_INC          byte increment between sequential fetches
//   *_DEF           default widths/depth used by the top-level parameters
//   fetch_pkt_t     {pc, instr} packet as seen by the instruction queue
package fetch_pkg;

    localparam int ADDR_WIDTH_DEF  = 32;
    localparam int INSTR_WIDTH_DEF = 32;
    localparam int SKID_DEPTH_DEF  = 2;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] PC_INC   = 32'd4;

    typedef struct packed {
        logic [ADDR_WIDTH_DEF-1:0]  pc;
        logic [INSTR_WIDTH_DEF-1:0] instr;
    } fetch_pkt_t;

endpackage

// File: rtl/fetch_skid_fifo.sv
// Small circular FIFO holding fetched packets until the queue accepts them.
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   clear           flush: empties the FIFO (wins over push/pop)
//   push, push_data write one packet at the tail
//   pop             retire the packet at the head
//   count           number of valid entries, 0..DEPTH
//   head_data       packet at the head (meaningful when count > 0)
module fetch_skid_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         clear,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic [WIDTH-1:0]             head_data
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH-1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= ptr_next(tail);
            if (pop)  head <= ptr_next(head);
            unique case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; validity is tracked by count.
    always_ff @(posedge clk) begin
        if (push && !clear && !reset) mem[tail] <= push_data;
    end

    assign head_data = mem[head];

endmodule

// File: rtl/fetch_feeder.sv
// Sequential instruction fetch feeding the instruction queue.
// Issues PCs to a one-cycle-latency instruction memory, captures responses in
// a skid FIFO and pushes {pc, instr} packets into the queue.
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   stall           global stall: no issue, no enque (responses still captured)
//   flush           discard all in-flight/buffered work, restart at redirect_pc
//   redirect_pc     restart PC used on flush
//   imem_req        memory read request this cycle
//   imem_addr       request address (current PC)
//   imem_data       read data, valid the cycle after imem_req
//   halt            queue full backpressure
//   enque           push packet to queue
//   enque_data      {pc, instr}, pc in the MSBs; zero when enque is low
// SKID_DEPTH must be at least 2.
module fetch_feeder
    import fetch_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = ADDR_WIDTH_DEF,
    parameter int                    INSTR_WIDTH = INSTR_WIDTH_DEF,
    parameter int                    SKID_DEPTH  = SKID_DEPTH_DEF,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = ADDR_WIDTH'(fetch_pkg::RESET_PC)
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              stall,
    input  logic                              flush,
    input  logic [ADDR_WIDTH-1:0]             redirect_pc,
    output logic                              imem_req,
    output logic [ADDR_WIDTH-1:0]             imem_addr,
    input  logic [INSTR_WIDTH-1:0]            imem_data,
    input  logic                              halt,
    output logic                              enque,
    output logic [ADDR_WIDTH+INSTR_WIDTH-1:0] enque_data
);

    localparam int PKT_W = ADDR_WIDTH + INSTR_WIDTH;
    localparam int CNT_W = $clog2(SKID_DEPTH+1);
    localparam int OCC_W = CNT_W + 1;

    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] inflight_pc;
    logic                  inflight;
    logic                  drop;
    logic                  started;
    logic [CNT_W-1:0]      count;
    logic [PKT_W-1:0]      head_data;
    logic [OCC_W-1:0]      occupancy;
    logic                  capture;

    // A request is only issued if its response is guaranteed a skid slot,
    // counting the response that is already on its way back.
    assign occupancy = OCC_W'(count) + OCC_W'(inflight);

    // started keeps both handshakes quiet for the first cycle out of reset.
    assign imem_req  = ~reset & started & ~stall & ~flush
                     & (occupancy < OCC_W'(SKID_DEPTH));
    assign imem_addr = pc;

    assign enque      = ~reset & started & ~halt & ~stall & ~flush & (count != '0);
    assign enque_data = enque ? head_data : '0;

    assign capture = inflight & ~drop;

    always_ff @(posedge clk) begin
        if (reset) begin
            pc          <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            drop        <= 1'b0;
            started     <= 1'b0;
        end else begin
            started <= 1'b1;
            drop    <= 1'b0;
            if (flush) begin
                pc       <= redirect_pc;
                inflight <= 1'b0;
                drop     <= inflight;
            end else if (imem_req) begin
                pc          <= pc + ADDR_WIDTH'(PC_INC);
                inflight    <= 1'b1;
                inflight_pc <= pc;
            end else begin
                inflight <= 1'b0;
            end
        end
    end

    fetch_skid_fifo #(
        .WIDTH (PKT_W),
        .DEPTH (SKID_DEPTH)
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .clear     (flush),
        .push      (capture),
        .push_data ({inflight_pc, imem_data}),
        .pop       (enque),
        .count     (count),
        .head_data (head_data)
    );

endmodule
